// File: rtl/mpt_pkg.sv
// mpt_pkg: walker transaction type, stage FSM states and the response merge helper.
package mpt_pkg;
  localparam int SPA_W = 16;
  localparam int RPA_W = 16;
  typedef struct packed {
    logic [RPA_W-1:0] rpa;
    logic [SPA_W-1:0] spa;
  } mptw_transaction_t;
  typedef enum logic {RUN, DRAIN} mpt_state_e;
  function automatic mptw_transaction_t with_rpa(mptw_transaction_t t, logic [RPA_W-1:0] rpa);
    with_rpa = t;
    with_rpa.rpa = rpa;
  endfunction
endpackage

// File: rtl/mpt_sync_fifo.sv
// mpt_sync_fifo: circular-buffer FIFO; a pushed entry is visible the cycle after, sync clear.
module mpt_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           clr,
  input  logic                           push,
  input  logic [WIDTH-1:0]               wdata,
  input  logic                           pop,
  output logic [WIDTH-1:0]               rdata,
  output logic [$clog2(DEPTH+1)-1:0]     count
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rptr, wptr;
  logic do_push, do_pop;
  function automatic logic [AW-1:0] inc(logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + AW'(1);
  endfunction
  assign do_push = push && count != CW'(DEPTH);
  assign do_pop = pop && count != '0;
  assign rdata = count != '0 ? mem[rptr] : '0;
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr) begin
      rptr <= '0;
      wptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= inc(wptr);
      if (do_pop) rptr <= inc(rptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk_i) if (do_push) mem[wptr] <= wdata;
endmodule

// File: rtl/mpt_mem_read_stage_v2.sv
// mpt_mem_read_stage_v2: issues one memory read per walker transaction, returns responses in order,
// and on flush drains still-outstanding reads before accepting new work.
module mpt_mem_read_stage_v2
  import mpt_pkg::*;
#(
  parameter int PIPELINE_SLAVE_DATA_WIDTH  = 32,
  parameter int PIPELINE_MASTER_DATA_WIDTH = 32,
  parameter int MAX_OUTSTANDING            = 4,
  parameter int RESP_FIFO_DEPTH            = 4,
  parameter int MEMORY_DATA_WIDTH          = 32,
  parameter int MEMORY_ADDR_WIDTH          = 32
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  flush_i,
  input  logic                                  stage_slave_valid,
  output logic                                  stage_slave_ready,
  input  logic [PIPELINE_SLAVE_DATA_WIDTH-1:0]  stage_slave_data,
  output logic                                  stage_master_valid,
  input  logic                                  stage_master_ready,
  output logic [PIPELINE_MASTER_DATA_WIDTH-1:0] stage_master_data,
  output logic                                  memory_master_mem_req,
  input  logic                                  memory_master_mem_gnt,
  output logic [MEMORY_ADDR_WIDTH-1:0]          memory_master_mem_addr,
  input  logic                                  memory_master_mem_valid,
  input  logic [MEMORY_DATA_WIDTH-1:0]          memory_master_mem_rdata,
  output logic                                  memory_master_mem_we,
  output logic [MEMORY_DATA_WIDTH/8-1:0]        memory_master_mem_be,
  output logic [MEMORY_DATA_WIDTH-1:0]          memory_master_mem_wdata
);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int RCW = $clog2(RESP_FIFO_DEPTH + 1);
  mpt_state_e state, state_nxt;
  logic [OW-1:0] outstanding, drop_cnt, drop_nxt, pend_count;
  logic [RCW-1:0] resp_count;
  logic armed, live, run, credit, grant, take, flush_run, unused_bits;
  mptw_transaction_t slave_txn, pend_head, resp_head;
  // armed keeps every output quiet for the first cycle after reset
  assign live = rst_ni && armed;
  assign run = state == RUN;
  assign slave_txn = stage_slave_data;
  assign credit = outstanding < OW'(MAX_OUTSTANDING) &&
                  int'(outstanding) + int'(resp_count) < RESP_FIFO_DEPTH;
  assign memory_master_mem_req = live && run && !flush_i && stage_slave_valid && credit;
  assign memory_master_mem_addr = memory_master_mem_req ? MEMORY_ADDR_WIDTH'(slave_txn.spa) : '0;
  assign grant = memory_master_mem_req && memory_master_mem_gnt;
  assign stage_slave_ready = grant;
  assign take = run && !flush_i && memory_master_mem_valid && outstanding != '0;
  assign flush_run = run && flush_i;
  assign drop_nxt = outstanding - OW'(memory_master_mem_valid && outstanding != '0);
  assign stage_master_valid = live && resp_count != '0;
  assign stage_master_data = stage_master_valid ? resp_head : '0;
  assign memory_master_mem_we = 1'b0;
  assign memory_master_mem_be = '0;
  assign memory_master_mem_wdata = '0;
  assign unused_bits = ^{memory_master_mem_rdata[MEMORY_DATA_WIDTH-1:RPA_W], pend_count};
  always_comb
    state_nxt = flush_run ? (drop_nxt != '0 ? DRAIN : RUN) :
                (!run && memory_master_mem_valid && drop_cnt == OW'(1)) ? RUN : state;
  always_ff @(posedge clk_i) state <= !rst_ni ? RUN : state_nxt;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      armed <= 1'b0;
      outstanding <= '0;
      drop_cnt <= '0;
    end else begin
      armed <= 1'b1;
      outstanding <= flush_run ? '0 : outstanding + OW'(grant) - OW'(take);
      drop_cnt <= flush_run ? drop_nxt :
                  (!run && memory_master_mem_valid && drop_cnt != '0) ? drop_cnt - OW'(1) : drop_cnt;
    end
  end
  stray_resp: cover property (@(posedge clk_i) rst_ni && run && memory_master_mem_valid && outstanding == '0);
  mpt_sync_fifo #(.WIDTH($bits(mptw_transaction_t)), .DEPTH(MAX_OUTSTANDING)) u_pend (
    .clk_i(clk_i), .rst_ni(rst_ni), .clr(flush_run), .push(grant), .wdata(slave_txn),
    .pop(take), .rdata(pend_head), .count(pend_count)
  );
  mpt_sync_fifo #(.WIDTH($bits(mptw_transaction_t)), .DEPTH(RESP_FIFO_DEPTH)) u_resp (
    .clk_i(clk_i), .rst_ni(rst_ni), .clr(flush_run), .push(take),
    .wdata(with_rpa(pend_head, memory_master_mem_rdata[RPA_W-1:0])),
    .pop(stage_master_valid && stage_master_ready), .rdata(resp_head), .count(resp_count)
  );
endmodule

// File: tb/tb_mpt_mem_read_stage_v2.sv
// tb_mpt_mem_read_stage_v2: directed vectors with hand-computed expectations for the read stage.
module tb_mpt_mem_read_stage_v2;
  logic clk_i = 1'b0;
  logic rst_ni, flush_i, sv, sr, mvld, mrdy, req, gnt, mv, we;
  logic [31:0] sdata, mdata, addr, rdata, wdata;
  logic [3:0] be;
  int checks = 0, failures = 0;
  always #5 clk_i = ~clk_i;
  mpt_mem_read_stage_v2 dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .stage_slave_valid(sv), .stage_slave_ready(sr), .stage_slave_data(sdata),
    .stage_master_valid(mvld), .stage_master_ready(mrdy), .stage_master_data(mdata),
    .memory_master_mem_req(req), .memory_master_mem_gnt(gnt), .memory_master_mem_addr(addr),
    .memory_master_mem_valid(mv), .memory_master_mem_rdata(rdata),
    .memory_master_mem_we(we), .memory_master_mem_be(be), .memory_master_mem_wdata(wdata)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask
  task automatic drive(input logic v, input logic [15:0] spa, input logic g, input logic m,
                       input logic [15:0] rd, input logic r, input logic f);
    sv = v; sdata = {16'h0, spa}; gnt = g; mv = m; rdata = {16'h0, rd}; mrdy = r; flush_i = f;
    #2;
  endtask
  task automatic idle();
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
  endtask
  initial begin
    rst_ni = 1'b0;
    drive(1'b1, 16'h0E, 1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
    step();
    step();
    drive(1'b1, 16'h0E, 1'b1, 1'b1, 16'h55, 1'b1, 1'b0);
    check("rst_req", req, 0);
    check("rst_sready", sr, 0);
    check("rst_mvalid", mvld, 0);
    check("rst_mdata", mdata, 0);
    check("rst_addr", addr, 0);
    check("rst_we_be_wdata", {we, be, wdata[26:0]}, 0);
    step();
    rst_ni = 1'b1;
    for (int c = 0; c <= 8; c++) begin
      drive(c <= 4, 16'(32'h0F + c), 1'b1, c >= 3 && c <= 6, 16'(32'hA0 + c - 3), 1'b1, 1'b0);
      check($sformatf("b2b_req%0d", c), req, 32'(c >= 1 && c <= 4));
      check($sformatf("b2b_addr%0d", c), addr, (c >= 1 && c <= 4) ? 32'h0F + c : 0);
      check($sformatf("b2b_sready%0d", c), sr, 32'(c >= 1 && c <= 4));
      check($sformatf("b2b_mvalid%0d", c), mvld, 32'(c >= 4 && c <= 7));
      check($sformatf("b2b_mdata%0d", c), mdata,
            (c >= 4 && c <= 7) ? {16'(32'hA0 + c - 4), 16'(32'h10 + c - 4)} : 0);
      step();
    end
    for (int s = 0; s < 3; s++) begin
      drive(1'b1, 16'h30, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
      check($sformatf("stall_req%0d", s), req, 1);
      check($sformatf("stall_addr%0d", s), addr, 32'h30);
      check($sformatf("stall_sready%0d", s), sr, 0);
      step();
    end
    drive(1'b1, 16'h30, 1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
    check("stall_grant", sr, 1);
    step();
    drive(1'b0, 16'h0, 1'b0, 1'b1, 16'hC0, 1'b1, 1'b0);
    check("stall_mvalid_pre", mvld, 0);
    step();
    idle();
    check("stall_mvalid", mvld, 1);
    check("stall_mdata", mdata, 32'h00C0_0030);
    step();
    idle();
    check("stall_empty", mvld, 0);
    step();
    for (int d = 1; d <= 12; d++) begin
      drive(d <= 8, d <= 4 ? 16'(32'h1F + d) : 16'h24, d <= 8, (d >= 3 && d <= 6) || d == 10,
            d == 10 ? 16'hB4 : 16'(32'hB0 + d - 3), d >= 7, 1'b0);
      check($sformatf("bp_req%0d", d), req, 32'((d >= 1 && d <= 4) || d == 8));
      check($sformatf("bp_mvalid%0d", d), mvld, 32'(d >= 4 && d <= 11));
      check($sformatf("bp_mdata%0d", d), mdata,
            (d >= 4 && d <= 7) ? 32'h00B0_0020 :
            (d >= 8 && d <= 11) ? {16'(32'hB0 + d - 7), 16'(32'h20 + d - 7)} : 0);
      step();
    end
    drive(1'b1, 16'h40, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    step();
    drive(1'b1, 16'h41, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    step();
    drive(1'b1, 16'h42, 1'b1, 1'b1, 16'hD0, 1'b0, 1'b0);
    step();
    drive(1'b1, 16'h43, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    check("fl_req4", req, 1);
    step();
    drive(1'b1, 16'h44, 1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
    check("fl_req_flush", req, 0);
    check("fl_mvalid_flush", mvld, 1);
    check("fl_mdata_flush", mdata, 32'h00D0_0040);
    step();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 16'h50, 1'b1, 1'b1, 16'hDD, 1'b1, 1'b0);
      check($sformatf("drain_req%0d", k), req, 0);
      check($sformatf("drain_sready%0d", k), sr, 0);
      check($sformatf("drain_mvalid%0d", k), mvld, 0);
      step();
    end
    drive(1'b1, 16'h50, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    check("drain_done_req", req, 1);
    check("drain_done_mvalid", mvld, 0);
    step();
    idle();
    step();
    drive(1'b1, 16'h60, 1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
    step();
    drive(1'b1, 16'h61, 1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
    step();
    drive(1'b0, 16'h0, 1'b0, 1'b1, 16'hEE, 1'b1, 1'b1);
    check("co_req_flush", req, 0);
    step();
    drive(1'b1, 16'h70, 1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
    check("co_req_drain", req, 0);
    check("co_mvalid_drain", mvld, 0);
    step();
    drive(1'b1, 16'h70, 1'b1, 1'b1, 16'hEE, 1'b1, 1'b0);
    check("co_req_last", req, 0);
    step();
    drive(1'b1, 16'h70, 1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
    check("co_req_run", req, 1);
    check("co_addr_run", addr, 32'h70);
    check("co_sready_run", sr, 1);
    step();
    idle();
    step();
    drive(1'b0, 16'h0, 1'b0, 1'b1, 16'hE0, 1'b1, 1'b0);
    check("co_mvalid_pre", mvld, 0);
    step();
    idle();
    check("co_mvalid", mvld, 1);
    check("co_mdata", mdata, 32'h00E0_0070);
    step();
    idle();
    check("co_empty", mvld, 0);
    step();
    drive(1'b1, 16'h80, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    step();
    drive(1'b1, 16'h81, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    step();
    drive(1'b1, 16'h82, 1'b1, 1'b1, 16'hF0, 1'b0, 1'b0);
    step();
    rst_ni = 1'b0;
    drive(1'b1, 16'h83, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    check("mr_req", req, 0);
    check("mr_sready", sr, 0);
    check("mr_mvalid", mvld, 0);
    check("mr_mdata", mdata, 0);
    check("mr_addr", addr, 0);
    step();
    rst_ni = 1'b1;
    drive(1'b1, 16'h83, 1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
    check("mr_after_req", req, 0);
    check("mr_after_sready", sr, 0);
    check("mr_after_mvalid", mvld, 0);
    check("mr_after_mdata", mdata, 0);
    check("mr_after_addr", addr, 0);
    step();
    drive(1'b0, 16'h0, 1'b0, 1'b1, 16'hFF, 1'b1, 1'b0);
    check("stray_mvalid0", mvld, 0);
    step();
    idle();
    check("stray_mvalid1", mvld, 0);
    check("stray_mdata1", mdata, 0);
    step();
    drive(1'b1, 16'h90, 1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
    check("recover_req", req, 1);
    check("recover_addr", addr, 32'h90);
    step();
    idle();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
